bcd_score_accumulator: RTL and testbench
========================================

# bcd_score_accumulator

Parametrised multi-digit BCD accumulator, the next generation of the single-digit 0–9 up-counter. Adds a multi-digit BCD operand to a held value, or subtracts it, one digit per clock, with a ready/valid handshake. Also supports synchronous load and clear, and wrap or saturate at the range limits. Sits between game logic (pellet/ghost/fruit events issue point values) and the score/timer display digit decoders.

## Interface
Parameters:
- `NUM_DIGITS`, default 4: number of BCD digits held; range 1–8.
- `SATURATE`, default 0: 0 wraps modulo 10^NUM_DIGITS; 1 clamps at all-9s (add) or all-0s (subtract).

Ports:
- `clk` in 1: the single clock; all state changes on its rising edge.
- `resetN` in 1: asynchronous, active-low reset.
- `enable_cnt` in 1: gates acceptance of new add/sub requests; has no effect on an operation already in flight.
- `clear` in 1: synchronous clear; highest priority after reset.
- `load` in 1: synchronous load of `load_value`; accepted only in IDLE.
- `load_value` in 4*NUM_DIGITS: BCD load data.
- `add_valid` in 1: request strobe.
- `add_value` in 4*NUM_DIGITS: BCD operand; digit 0 at bits [3:0].
- `sub` in 1: 0 = add, 1 = subtract; sampled with `add_valid`.
- `ready` out 1: high only in IDLE.
- `count` out 4*NUM_DIGITS: committed BCD value.
- `zero` out 1: combinational, `count` == 0.
- `done_pulse` out 1: one-cycle pulse when a result commits.
- `overflow_pulse` out 1: one-cycle pulse, coincident with `done_pulse`, on carry-out (add) or borrow-out (subtract).

## Operation
- FSM states: IDLE, ADD, COMMIT.
- IDLE → ADD on accept, where accept = `add_valid` && `ready` && `enable_cnt` && !`load` && !`clear`.
  - At accept: latch operand and `sub`; copy `count` into the shadow register; digit index = 0; carry/borrow = 0.
- ADD: one digit per cycle, LSB first.
  - Add: s = a + b + c; if s > 9, emit s − 10 and set c = 1.
  - Subtract: d = a − b − c; if d < 0, emit d + 10 and set c = 1.
  - Each result is written into the shadow register only. After digit NUM_DIGITS−1, go to COMMIT.
- COMMIT: write `count`, assert `done_pulse` and (if final c = 1) `overflow_pulse`, then return to IDLE.
  - If final c = 1 and SATURATE = 1, write all-9s (add) or all-0s (subtract) instead of the shadow value.
  - `count` never shows a partial result.
- Operand digits > 9 (in `add_value` or `load_value`) are clamped to 9 at latch time.
- `load` in IDLE: `count` takes `load_value` next edge. It wins over a simultaneous `add_valid`, which is not accepted. No pulses.
- `clear`: `count` becomes 0 and the FSM returns to IDLE next edge from any state. Any in-flight operation is aborted with no `done_pulse` or `overflow_pulse`. `clear` beats `load` and `add_valid`.
- `load` outside IDLE is ignored.

## Timing
- Reset values: `count` = 0, `zero` = 1, `ready` = 1, `done_pulse` = 0, `overflow_pulse` = 0, FSM = IDLE, shadow = 0.
- Let edge k be the accepting edge:
  - Edges k+1 … k+NUM_DIGITS: ADD, one digit each.
  - Edge k+NUM_DIGITS+1: COMMIT; `count` updates; pulses are high for the following cycle.
  - Edge k+NUM_DIGITS+2: earliest next accept.
- Accept-to-`count` latency is NUM_DIGITS+1 cycles. Throughput is one operation per NUM_DIGITS+2 cycles.
- `ready` falls in the cycle after accept and stays low until the FSM returns to IDLE.
- The source must hold `add_valid` and its data until the accepting edge.
- Asynchronous reset mid-operation returns every output immediately to its reset value.

## Structure
- Package `bcd_pkg` holds:
  - FSM state enum `acc_state_t`
  - `bcd_digit_t` (logic [3:0])
  - constants `BCD_MAX` = 4'h9 and `BCD_BASE` = 10
  - clamp function `bcd_clamp`
- One combinational sub-module, `bcd_digit_addsub`.
  - Inputs: a, b, cin, sub.
  - Outputs: digit, cout.
  - Instantiated once and time-multiplexed over the digit index.
- Top level contains the FSM, shadow register, index counter, and operand register.

## Test plan
All scenarios use NUM_DIGITS = 4.
- Reset: hold `resetN` low → `count` = 0000, `zero` = 1, `ready` = 1, both pulses 0.
- Chained carry: load 0995, add 0010 → `count` = 1005 exactly 5 cycles after accept; one `done_pulse`; `ready` low 5 cycles; no overflow.
- Overflow: 9990 + 0015.
  - SATURATE = 0 → 0005 with `overflow_pulse`.
  - SATURATE = 1 → 9999 with `overflow_pulse`.
- Underflow: 0003 − 0007.
  - SATURATE = 0 → 9996 with `overflow_pulse`.
  - SATURATE = 1 → 0000, `zero` = 1.
- Abort: `clear` on the 2nd ADD cycle → `count` = 0000 next edge, no `done_pulse`, `ready` = 1 next cycle. Repeat with `resetN` pulsed mid-ADD → immediate reset values.
- Gating and clamping:
  - `add_valid` with `enable_cnt` = 0 → no accept, `count` unchanged.
  - 0000 + 00C0 → 0090.
  - `load` and `add_valid` in the same cycle → load value taken, add not accepted.

Source files
------------

// File: rtl/bcd_score_accumulator_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bcd_pkg
// Brief   : Shared types, constants and helpers for the BCD score accumulator
// Revision: 1.0 - initial release
// ============================================================================
package bcd_pkg;

  // Accumulator control states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ADD    = 2'd1,
    ST_COMMIT = 2'd2
  } acc_state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX  = 4'h9;
  localparam int         BCD_BASE = 10;

  // Illegal BCD nibbles (A-F) are treated as 9
  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_score_accumulator_digit_addsub.sv
`default_nettype none
// ============================================================================
// Module  : bcd_digit_addsub
// Brief   : Single-digit BCD add/subtract with carry/borrow in and out
// Revision: 1.0 - initial release
// ============================================================================
module bcd_digit_addsub
  import bcd_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       cin,
  input  logic       sub,
  output bcd_digit_t digit,
  output logic       cout
);

  // Operands are valid BCD, so the sum spans 0..19 and the difference -10..9;
  // five bits hold both, with bit 4 acting as the sign of the difference.
  logic [4:0] w_sum;
  logic [4:0] w_diff;

  assign w_sum  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
  assign w_diff = {1'b0, a} - {1'b0, b} - {4'b0000, cin};

  // Decimal correction of the binary result
  always_comb begin
    digit = w_sum[3:0];
    cout  = 1'b0;
    if (sub) begin
      digit = w_diff[3:0];
      if (w_diff[4]) begin
        digit = 4'(w_diff + 5'(BCD_BASE));
        cout  = 1'b1;
      end
    end else if (w_sum > 5'(BCD_MAX)) begin
      digit = 4'(w_sum - 5'(BCD_BASE));
      cout  = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bcd_score_accumulator.sv
`default_nettype none
// ============================================================================
// Module  : bcd_score_accumulator
// Brief   : Multi-digit BCD accumulator, digit-serial add/subtract with
//           ready/valid request, synchronous load/clear, wrap or saturate
// Revision: 1.0 - initial release
// ============================================================================
module bcd_score_accumulator
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter bit SATURATE   = 1'b0
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    enable_cnt,
  input  logic                    clear,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  input  logic                    add_valid,
  input  logic [4*NUM_DIGITS-1:0] add_value,
  input  logic                    sub,
  output logic                    ready,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic                    zero,
  output logic                    done_pulse,
  output logic                    overflow_pulse
);

  localparam int                W         = 4 * NUM_DIGITS;
  localparam int                IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [W-1:0]      ALL_NINES = {NUM_DIGITS{BCD_MAX}};

  acc_state_t       state_q, state_d;
  logic [W-1:0]     count_q;
  logic [W-1:0]     shadow_q;   // result under construction, never visible
  logic [W-1:0]     operand_q;
  logic             sub_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx_q;
  logic             done_q;
  logic             ovf_q;

  logic [W-1:0]     w_add_clamped;
  logic [W-1:0]     w_load_clamped;
  bcd_digit_t       w_dig_a, w_dig_b, w_dig_res;
  logic             w_dig_cout;
  logic             w_accept;
  logic             w_last_digit;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_clamp
    assign w_add_clamped[4*g +: 4]  = bcd_clamp(add_value[4*g +: 4]);
    assign w_load_clamped[4*g +: 4] = bcd_clamp(load_value[4*g +: 4]);
  end

  assign ready        = (state_q == ST_IDLE);
  assign w_accept     = add_valid && ready && enable_cnt && !load && !clear;
  assign w_last_digit = (idx_q == LAST_IDX);

  // One digit slice shared across all positions, steered by the index
  assign w_dig_a = shadow_q[4*idx_q +: 4];
  assign w_dig_b = operand_q[4*idx_q +: 4];

  bcd_digit_addsub u_digit (
    .a     (w_dig_a),
    .b     (w_dig_b),
    .cin   (carry_q),
    .sub   (sub_q),
    .digit (w_dig_res),
    .cout  (w_dig_cout)
  );

  // State register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; clear forces IDLE from anywhere
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (w_accept)     state_d = ST_ADD;
      ST_ADD:    if (w_last_digit) state_d = ST_COMMIT;
      ST_COMMIT:                   state_d = ST_IDLE;
      default:                     state_d = ST_IDLE;
    endcase
    if (clear) state_d = ST_IDLE;
  end

  // Datapath: load/latch in IDLE, digit-serial update in ADD, publish in COMMIT
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count_q   <= '0;
      shadow_q  <= '0;
      operand_q <= '0;
      sub_q     <= 1'b0;
      carry_q   <= 1'b0;
      idx_q     <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
      if (clear) begin
        count_q  <= '0;
        shadow_q <= '0;
        carry_q  <= 1'b0;
        idx_q    <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (load) begin
              count_q <= w_load_clamped;
            end else if (w_accept) begin
              operand_q <= w_add_clamped;
              sub_q     <= sub;
              shadow_q  <= count_q;
              idx_q     <= '0;
              carry_q   <= 1'b0;
            end
          end
          ST_ADD: begin
            shadow_q[4*idx_q +: 4] <= w_dig_res;
            carry_q                <= w_dig_cout;
            idx_q                  <= idx_q + 1'b1;
          end
          ST_COMMIT: begin
            if (carry_q && SATURATE) count_q <= sub_q ? '0 : ALL_NINES;
            else                     count_q <= shadow_q;
            done_q <= 1'b1;
            ovf_q  <= carry_q;
          end
          default: ;
        endcase
      end
    end
  end

  assign count          = count_q;
  assign zero           = (count_q == '0);
  assign done_pulse     = done_q;
  assign overflow_pulse = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_score_accumulator.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_bcd_score_accumulator
// Brief   : Directed self-checking bench, wrapping and saturating instances
// Revision: 1.0 - initial release
// ============================================================================
module tb_bcd_score_accumulator;

  logic        clk = 1'b0;
  logic        resetN, enable_cnt, clear, load, add_valid, sub;
  logic [15:0] load_value, add_value;

  logic        ready0, zero0, done0, ovf0;
  logic [15:0] count0;
  logic        ready1, zero1, done1, ovf1;
  logic [15:0] count1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] c0;
    logic [15:0] c1;
    logic        ovf;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  bcd_score_accumulator #(.NUM_DIGITS(4), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .resetN(resetN), .enable_cnt(enable_cnt), .clear(clear),
    .load(load), .load_value(load_value), .add_valid(add_valid),
    .add_value(add_value), .sub(sub), .ready(ready0), .count(count0),
    .zero(zero0), .done_pulse(done0), .overflow_pulse(ovf0)
  );

  bcd_score_accumulator #(.NUM_DIGITS(4), .SATURATE(1'b1)) u_sat (
    .clk(clk), .resetN(resetN), .enable_cnt(enable_cnt), .clear(clear),
    .load(load), .load_value(load_value), .add_valid(add_valid),
    .add_value(add_value), .sub(sub), .ready(ready1), .count(count1),
    .zero(zero1), .done_pulse(done1), .overflow_pulse(ovf1)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int bcd2int(input logic [15:0] v);
    int r;
    logic [3:0] d;
    r = 0;
    for (int i = 3; i >= 0; i--) begin
      d = v[4*i +: 4];
      if (d > 4'd9) d = 4'd9;
      r = r * 10 + int'(d);
    end
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] r;
    int t;
    t = v;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Decimal reference: integer arithmetic then wrap or clamp to 0..9999
  task automatic model(input logic [15:0] base, input logic [15:0] opnd, input logic s,
                       input logic sat, output logic [15:0] res, output logic ovf);
    int r;
    r   = s ? bcd2int(base) - bcd2int(opnd) : bcd2int(base) + bcd2int(opnd);
    ovf = 1'b0;
    if (r > 9999) begin
      ovf = 1'b1;
      r   = sat ? 9999 : r - 10000;
    end else if (r < 0) begin
      ovf = 1'b1;
      r   = sat ? 0 : r + 10000;
    end
    res = int2bcd(r);
  endtask

  task automatic do_load(input logic [15:0] v);
    load       = 1'b1;
    load_value = v;
    tick();
    load = 1'b0;
    check("load_wrap", count0, int2bcd(bcd2int(v)));
    check("load_sat",  count1, int2bcd(bcd2int(v)));
  endtask

  task automatic do_op(input logic [15:0] a, input logic s);
    logic [15:0] old0, r0, r1;
    logic        o0, o1, seen;
    int          cyc, low;
    exp_t        e;
    old0 = count0;
    model(count0, a, s, 1'b0, r0, o0);
    model(count1, a, s, 1'b1, r1, o1);
    e.c0 = r0; e.c1 = r1; e.ovf = o0;
    add_value  = a;
    sub        = s;
    enable_cnt = 1'b1;
    add_valid  = 1'b1;
    tick();
    add_valid = 1'b0;
    sb.push_back(e);
    cyc = 0; low = 0; seen = 1'b0;
    while (!seen && cyc < 20) begin
      if (!ready0) low++;
      if (done0) seen = 1'b1;
      else begin
        check("no_partial", count0, old0);
        tick();
        cyc++;
      end
    end
    if (!seen) check("done_timeout", 16'(done0), 16'h1);
    check("latency",   16'(cyc), 16'd5);
    check("ready_low", 16'(low), 16'd5);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("count_wrap", count0, e.c0);
      check("count_sat",  count1, e.c1);
      check("ovf_wrap",   16'(ovf0), 16'(e.ovf));
      check("ovf_sat",    16'(ovf1), 16'(e.ovf));
      check("done_sat",   16'(done1), 16'h1);
    end
    tick();
    check("done_one_cycle", 16'(done0), 16'h0);
    check("ovf_one_cycle",  16'(ovf0),  16'h0);
    check("ready_back",     16'(ready0), 16'h1);
  endtask

  // Start an add that is expected to be killed before commit
  task automatic start_abortable;
    add_value  = 16'h0111;
    sub        = 1'b0;
    enable_cnt = 1'b1;
    add_valid  = 1'b1;
    tick();
    add_valid = 1'b0;
    check("abort_accepted", 16'(ready0), 16'h0);
    tick();
  endtask

  initial begin
    resetN = 1'b0; enable_cnt = 1'b0; clear = 1'b0; load = 1'b0;
    add_valid = 1'b0; sub = 1'b0; load_value = '0; add_value = '0;
    repeat (3) tick();
    check("rst_count", count0, 16'h0000);
    check("rst_zero",  16'(zero0),  16'h1);
    check("rst_ready", 16'(ready0), 16'h1);
    check("rst_done",  16'(done0),  16'h0);
    check("rst_ovf",   16'(ovf0),   16'h0);
    check("rst_count_sat", count1, 16'h0000);
    resetN = 1'b1;
    tick();

    do_load(16'h0995);
    do_op(16'h0010, 1'b0);           // chained carry -> 1005

    do_load(16'h9990);
    do_op(16'h0015, 1'b0);           // 0005 wrap / 9999 saturate

    do_load(16'h0003);
    do_op(16'h0007, 1'b1);           // 9996 wrap / 0000 saturate
    check("zero_sat_underflow",  16'(zero1), 16'h1);
    check("zero_wrap_underflow", 16'(zero0), 16'h0);

    do_load(16'h00F0);               // load digit clamp -> 0090
    do_load(16'h0000);
    do_op(16'h00C0, 1'b0);           // operand clamp -> 0090

    enable_cnt = 1'b0;
    add_value  = 16'h0001;
    add_valid  = 1'b1;
    repeat (3) begin
      tick();
      check("gate_ready", 16'(ready0), 16'h1);
      check("gate_count", count0, 16'h0090);
    end
    add_valid  = 1'b0;
    enable_cnt = 1'b1;

    load = 1'b1; load_value = 16'h1234;
    add_valid = 1'b1; add_value = 16'h0001; sub = 1'b0;
    tick();
    load = 1'b0; add_valid = 1'b0;
    check("load_wins_count", count0, 16'h1234);
    check("load_wins_ready", 16'(ready0), 16'h1);
    repeat (7) begin
      tick();
      check("load_wins_no_done", 16'(done0), 16'h0);
    end
    check("load_wins_hold", count0, 16'h1234);

    do_load(16'h0500);
    start_abortable();               // now in the 2nd ADD cycle
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_count", count0, 16'h0000);
    check("clr_ready", 16'(ready0), 16'h1);
    check("clr_done",  16'(done0),  16'h0);
    check("clr_zero",  16'(zero0),  16'h1);
    repeat (7) begin
      tick();
      check("clr_no_done", 16'(done0), 16'h0);
    end

    do_load(16'h0500);
    start_abortable();
    resetN = 1'b0;
    #1;
    check("arst_count", count0, 16'h0000);
    check("arst_zero",  16'(zero0),  16'h1);
    check("arst_ready", 16'(ready0), 16'h1);
    check("arst_done",  16'(done0),  16'h0);
    check("arst_ovf",   16'(ovf0),   16'h0);
    tick();
    resetN = 1'b1;
    repeat (7) begin
      tick();
      check("arst_no_done", 16'(done0), 16'h0);
    end
    check("arst_hold", count0, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
